multi_7_seg_mux: RTL and testbench



---
 rtl/multi_7_seg_mux.sv | 167 ++++++++++++++++
 tb/tb_multi_7_seg_mux.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_7_seg_mux.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous loads, leading-zero blanking and blinking.
// Outputs registered one cycle behind the scan counters; no flow control, load_i is a fire-and-forget strobe.
module multi_7_seg_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    load_i,
    input  logic                    lz_suppress_i,
    input  logic [NUM_DIGITS-1:0]   blink_en_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic                    frame_o
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FC_W  = $clog2(BLINK_FRAMES) + 1;

    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]        BLANK_N   = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]         FC_LAST   = FC_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0]   ONE       = NUM_DIGITS'(1);
    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{4'hA}};

    generate
        if (SCAN_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV ||
            NUM_DIGITS < 2 || NUM_DIGITS > 8 || BLINK_FRAMES < 1) begin : g_bad_params
            $error("multi_7_seg_mux: illegal parameter combination");
        end
    endgenerate

    function automatic logic [6:0] encode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            4'd10:   s = 7'b0000000;
            4'd11:   s = 7'b1110011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FC_W-1:0]         fc_q, fc_d;
    logic                    blink_q, blink_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    shown_q, shown_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    frame_q, frame_d;

    logic       boundary;
    logic       run;
    logic [3:0] nib;
    logic [3:0] code_sel;
    logic       blink_sel;

    always_comb begin
        boundary = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        frame_d = boundary;

        fc_d    = fc_q;
        blink_d = blink_q;
        if (boundary) begin
            if (fc_q == FC_LAST) begin
                fc_d    = '0;
                blink_d = ~blink_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end

        // New codes only reach the active register on a frame boundary, so a frame never mixes two words.
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        shown_d    = shown_q;
        if (boundary) begin
            if (load_i) begin
                active_d   = digits_i;
                pend_vld_d = 1'b0;
                shown_d    = 1'b1;
            end else if (pend_vld_q) begin
                active_d   = pending_q;
                pend_vld_d = 1'b0;
                shown_d    = 1'b1;
            end
        end else if (load_i) begin
            pending_d  = digits_i;
            pend_vld_d = 1'b1;
        end

        // Zero run scanned from the most significant digit; any non-zero code (including 10-15) ends it.
        run       = 1'b1;
        nib       = '0;
        code_sel  = 4'hA;
        blink_sel = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = active_q[4*k +: 4];
            run = run && (nib == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                code_sel  = (lz_suppress_i && run && k != 0) ? 4'hA : nib;
                blink_sel = blink_en_i[k];
            end
        end

        seg_d    = encode(code_sel);
        dig_en_d = '0;
        if (shown_q && cnt_q >= BLANK_N && !(blink_q && blink_sel)) begin
            dig_en_d = ONE << idx_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            fc_q       <= '0;
            blink_q    <= 1'b0;
            active_q   <= ALL_BLANK;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            shown_q    <= 1'b0;
            seg_q      <= '0;
            dig_en_q   <= '0;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            fc_q       <= fc_d;
            blink_q    <= blink_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            shown_q    <= shown_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
            frame_q    <= frame_d;
        end
    end

    assign seg_o    = seg_q;
    assign dig_en_o = dig_en_q;
    assign frame_o  = frame_q;
endmodule

// File: tb/tb_multi_7_seg_mux.sv
// Directed bench for multi_7_seg_mux with a 16-cycle frame (4 digits x 4 cycles per slot).
module tb_multi_7_seg_mux;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] digits_i = '0;
    logic        load_i = 1'b0;
    logic        lz_suppress_i = 1'b0;
    logic [3:0]  blink_en_i = '0;
    logic [6:0]  seg_o;
    logic [3:0]  dig_en_o;
    logic        frame_o;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt = 0;   // clock edges since the last reset release

    multi_7_seg_mux #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .digits_i(digits_i), .load_i(load_i),
        .lz_suppress_i(lz_suppress_i), .blink_en_i(blink_en_i),
        .seg_o(seg_o), .dig_en_o(dig_en_o), .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd0: s = 7'b1111110;  4'd1: s = 7'b0110000;
            4'd2: s = 7'b1101101;  4'd3: s = 7'b1111001;
            4'd4: s = 7'b0110011;  4'd5: s = 7'b1011011;
            4'd6: s = 7'b1011111;  4'd7: s = 7'b1110000;
            4'd8: s = 7'b1111111;  4'd9: s = 7'b1111011;
            4'd10: s = 7'b0000000; 4'd11: s = 7'b1110011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        ecnt++;
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        n_checks++;
        if (seg_o !== 7'd0 || dig_en_o !== 4'd0 || frame_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state seg=%b dig_en=%b frame=%b required all zero", seg_o, dig_en_o, frame_o);
        end
        rst_i = 1'b0;
        ecnt = 0;
        for (int j = 0; j < 48; j++) begin
            tick();
            n_checks++;
            if (seg_o !== 7'd0 || dig_en_o !== 4'd0 || frame_o !== (ecnt % 16 == 0)) begin
                n_errors++;
                $display("FAIL idle edge=%0d seg=%b dig_en=%b frame=%b required seg=0 dig_en=0 frame=%0d",
                         ecnt, seg_o, dig_en_o, frame_o, (ecnt % 16 == 0));
            end
        end
    endtask

    task automatic test_load();
        logic [15:0] codes;
        logic [6:0]  exp_seg;
        logic [3:0]  exp_en;
        int s, c;
        while (ecnt % 16 != 5) tick();
        digits_i = 16'h1234;
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
        digits_i = 16'hFFFF;
        while (ecnt % 16 != 0) begin
            tick();
            n_checks++;
            if (seg_o !== 7'd0 || dig_en_o !== 4'd0) begin
                n_errors++;
                $display("FAIL load_early edge=%0d seg=%b dig_en=%b required dark", ecnt, seg_o, dig_en_o);
            end
        end
        codes = 16'h1234;
        for (int j = 0; j < 16; j++) begin
            tick();
            s = j / 4;
            c = j % 4;
            exp_seg = seg_of(codes[4*s +: 4]);
            exp_en  = (c == 0) ? 4'b0000 : 4'(1 << s);
            n_checks++;
            if (seg_o !== exp_seg || dig_en_o !== exp_en) begin
                n_errors++;
                $display("FAIL load_frame j=%0d seg=%b dig_en=%b required seg=%b dig_en=%b",
                         j, seg_o, dig_en_o, exp_seg, exp_en);
            end
        end
    endtask

    task automatic test_blink();
        logic [15:0] codes;
        logic [6:0]  exp_seg;
        logic [3:0]  exp_en;
        int s, c, f, ph;
        codes = 16'h1234;
        blink_en_i = 4'b0010;
        for (int j = 0; j < 64; j++) begin
            tick();
            s  = (j % 16) / 4;
            c  = j % 4;
            f  = (ecnt - 1) / 16;
            ph = (f / 2) % 2;
            exp_seg = seg_of(codes[4*s +: 4]);
            exp_en  = (c == 0 || (s == 1 && ph == 1)) ? 4'b0000 : 4'(1 << s);
            n_checks++;
            if (seg_o !== exp_seg || dig_en_o !== exp_en) begin
                n_errors++;
                $display("FAIL blink frame=%0d j=%0d seg=%b dig_en=%b required seg=%b dig_en=%b",
                         f, j, seg_o, dig_en_o, exp_seg, exp_en);
            end
        end
        blink_en_i = 4'b0000;
    endtask

    task automatic test_lz();
        logic [15:0] words [3];
        logic [15:0] codes [3];
        logic        lz    [3];
        logic [6:0]  exp_seg;
        logic [3:0]  exp_en;
        int s, c;
        words[0] = 16'h0075; codes[0] = 16'hAA75; lz[0] = 1'b1;
        words[1] = 16'h0075; codes[1] = 16'h0075; lz[1] = 1'b0;
        words[2] = 16'h0000; codes[2] = 16'hAAA0; lz[2] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            lz_suppress_i = lz[t];
            if (t != 1) begin
                digits_i = words[t];
                load_i   = 1'b1;
                tick();
                load_i   = 1'b0;
                while (ecnt % 16 != 0) tick();
            end
            for (int j = 0; j < 16; j++) begin
                tick();
                s = j / 4;
                c = j % 4;
                exp_seg = seg_of(codes[t][4*s +: 4]);
                exp_en  = (c == 0) ? 4'b0000 : 4'(1 << s);
                n_checks++;
                if (seg_o !== exp_seg || dig_en_o !== exp_en) begin
                    n_errors++;
                    $display("FAIL lz case=%0d j=%0d seg=%b dig_en=%b required seg=%b dig_en=%b",
                             t, j, seg_o, dig_en_o, exp_seg, exp_en);
                end
            end
        end
        lz_suppress_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seg;
        logic [3:0] exp_en;
        int s, c;
        digits_i = 16'h1111;
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
        repeat (3) tick();
        digits_i = 16'h2222;
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
        while (ecnt % 16 != 0) tick();
        for (int j = 0; j < 16; j++) begin
            tick();
            s = j / 4;
            c = j % 4;
            exp_en = (c == 0) ? 4'b0000 : 4'(1 << s);
            n_checks++;
            if (seg_o !== seg_of(4'd2) || dig_en_o !== exp_en) begin
                n_errors++;
                $display("FAIL last_load_wins j=%0d seg=%b dig_en=%b required seg=%b dig_en=%b",
                         j, seg_o, dig_en_o, seg_of(4'd2), exp_en);
            end
        end
        while (ecnt % 16 != 15) tick();
        digits_i = 16'h3333;
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
        exp_seg  = seg_of(4'd3);
        for (int j = 0; j < 16; j++) begin
            tick();
            s = j / 4;
            c = j % 4;
            exp_en = (c == 0) ? 4'b0000 : 4'(1 << s);
            n_checks++;
            if (seg_o !== exp_seg || dig_en_o !== exp_en) begin
                n_errors++;
                $display("FAIL boundary_load j=%0d seg=%b dig_en=%b required seg=%b dig_en=%b",
                         j, seg_o, dig_en_o, exp_seg, exp_en);
            end
        end
    endtask

    task automatic test_async_reset();
        digits_i = 16'h1234;
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
        while (ecnt % 16 != 0) tick();
        repeat (6) tick();
        digits_i = 16'h5555;
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
        n_checks++;
        if (seg_o !== seg_of(4'd3) || dig_en_o !== 4'b0010) begin
            n_errors++;
            $display("FAIL pre_reset seg=%b dig_en=%b required seg=%b dig_en=0010", seg_o, dig_en_o, seg_of(4'd3));
        end
        #3;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (seg_o !== 7'd0 || dig_en_o !== 4'd0 || frame_o !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset seg=%b dig_en=%b frame=%b required all zero", seg_o, dig_en_o, frame_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ecnt  = 0;
        for (int j = 0; j < 32; j++) begin
            tick();
            n_checks++;
            if (seg_o !== 7'd0 || dig_en_o !== 4'd0 || frame_o !== (ecnt % 16 == 0)) begin
                n_errors++;
                $display("FAIL post_reset_dark edge=%0d seg=%b dig_en=%b frame=%b required seg=0 dig_en=0 frame=%0d",
                         ecnt, seg_o, dig_en_o, frame_o, (ecnt % 16 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_blink();
        test_lz();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
